// File: rtl/npu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : npu_pkg
// Purpose  : Shared types and helpers for the NPU attention-block loaders.
//            - loader_state_t : K/V row loader state encoding
//            - ceil_div()     : integer ceiling division for derived sizes
// Revision : 1.0 - initial release
// ============================================================================
package npu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_K = 2'd1,
        LOAD_V = 2'd2,
        DONE   = 2'd3
    } loader_state_t;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/kv_beat_packer.sv
`default_nettype none
// ============================================================================
// Module   : kv_beat_packer
// Purpose  : Assembles BEAT_BYTES-wide beats into an N-byte row.
// Ports    : clk, rst_n     - clock, async active-low reset
//            clear          - drop the partial row, restart at beat 0
//            accept         - a beat is taken this cycle
//            beat_data      - beat payload, byte b at [8b+:8]
//            row_next       - current row with this cycle's beat inserted
//            row_done       - accept of the final beat of a row (comb pulse)
// Revision : 1.0 - initial release
// ============================================================================
module kv_beat_packer
    import npu_pkg::*;
#(
    parameter int N          = 44,
    parameter int BEAT_BYTES = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    accept,
    input  logic [8*BEAT_BYTES-1:0] beat_data,
    output logic [8*N-1:0]          row_next,
    output logic                    row_done
);

    localparam int c_BPR = ceil_div(N, BEAT_BYTES);
    localparam int c_BCW = (c_BPR > 1) ? $clog2(c_BPR) : 1;
    localparam logic [c_BCW-1:0] c_LAST_BEAT = c_BCW'(c_BPR - 1);

    logic [c_BCW-1:0] r_beat_cnt;
    logic [8*N-1:0]   r_row;
    logic             w_last_beat;

    // Each row byte has a fixed beat slot; it takes the beat byte only while
    // that slot is the current beat. Beat bytes mapping past N have no row
    // byte and are therefore dropped.
    genvar j;
    generate
        for (j = 0; j < N; j++) begin : g_byte
            localparam logic [c_BCW-1:0] c_SLOT = c_BCW'(j / BEAT_BYTES);
            assign row_next[8*j +: 8] = (r_beat_cnt == c_SLOT)
                                      ? beat_data[8*(j % BEAT_BYTES) +: 8]
                                      : r_row[8*j +: 8];
        end
    endgenerate

    assign w_last_beat = (r_beat_cnt == c_LAST_BEAT);
    assign row_done    = accept & w_last_beat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat_cnt <= '0;
            r_row      <= '0;
        end else if (clear) begin
            r_beat_cnt <= '0;
        end else if (accept) begin
            r_row      <= row_next;
            r_beat_cnt <= w_last_beat ? '0 : r_beat_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/kv_row_loader.sv
`default_nettype none
// ============================================================================
// Module   : kv_row_loader
// Purpose  : Write-side feeder for the attention K and V buffers. Packs a
//            beat stream into N-byte rows, writes M rows to K then M rows to
//            V, and flags kv_loaded once both matrices are complete.
// Ports    : clk, rst_n               - clock, async active-low reset
//            start                    - begin / restart a K-then-V load
//            in_valid/in_data/in_ready- beat stream handshake
//            K_wr_en/addr/data        - K RAM write port (registered)
//            V_wr_en/addr/data        - V RAM write port (registered)
//            busy                     - load in progress
//            kv_loaded                - both matrices written
// Revision : 1.0 - initial release
// ============================================================================
module kv_row_loader
    import npu_pkg::*;
#(
    parameter int M          = 166,
    parameter int N          = 44,
    parameter int BEAT_BYTES = 8,
    parameter int AW         = $clog2(M)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    in_valid,
    input  logic [8*BEAT_BYTES-1:0] in_data,
    output logic                    in_ready,
    output logic                    K_wr_en,
    output logic [AW-1:0]           K_wr_addr,
    output logic [8*N-1:0]          K_wr_data,
    output logic                    V_wr_en,
    output logic [AW-1:0]           V_wr_addr,
    output logic [8*N-1:0]          V_wr_data,
    output logic                    busy,
    output logic                    kv_loaded
);

    localparam logic [AW-1:0] c_LAST_ROW = AW'(M - 1);

    loader_state_t  r_state;
    logic [AW-1:0]  r_row_cnt;
    logic           w_accept;
    logic           w_row_done;
    logic [8*N-1:0] w_row_next;

    // Readiness is a pure decode of the state register, so it never depends
    // on in_valid and cannot form a combinational loop with the source.
    assign in_ready = (r_state == LOAD_K) || (r_state == LOAD_V);
    assign busy     = in_ready;
    assign w_accept = in_valid & in_ready;

    kv_beat_packer #(
        .N          (N),
        .BEAT_BYTES (BEAT_BYTES)
    ) u_packer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (start),
        .accept    (w_accept),
        .beat_data (in_data),
        .row_next  (w_row_next),
        .row_done  (w_row_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_row_cnt <= '0;
            K_wr_en   <= 1'b0;
            K_wr_addr <= '0;
            K_wr_data <= '0;
            V_wr_en   <= 1'b0;
            V_wr_addr <= '0;
            V_wr_data <= '0;
            kv_loaded <= 1'b0;
        end else begin
            K_wr_en <= 1'b0;
            V_wr_en <= 1'b0;
            if (start) begin
                // Restart takes priority over everything, including a
                // final-beat accept in the same cycle: that row is dropped.
                r_state   <= LOAD_K;
                r_row_cnt <= '0;
                kv_loaded <= 1'b0;
            end else begin
                unique case (r_state)
                    LOAD_K: begin
                        if (w_row_done) begin
                            K_wr_en   <= 1'b1;
                            K_wr_addr <= r_row_cnt;
                            K_wr_data <= w_row_next;
                            if (r_row_cnt == c_LAST_ROW) begin
                                r_row_cnt <= '0;
                                r_state   <= LOAD_V;
                            end else begin
                                r_row_cnt <= r_row_cnt + 1'b1;
                            end
                        end
                    end
                    LOAD_V: begin
                        if (w_row_done) begin
                            V_wr_en   <= 1'b1;
                            V_wr_addr <= r_row_cnt;
                            V_wr_data <= w_row_next;
                            if (r_row_cnt == c_LAST_ROW) begin
                                r_row_cnt <= '0;
                                r_state   <= DONE;
                                kv_loaded <= 1'b1;
                            end else begin
                                r_row_cnt <= r_row_cnt + 1'b1;
                            end
                        end
                    end
                    IDLE, DONE: begin
                        r_state <= r_state;
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_kv_row_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_kv_row_loader
// Purpose  : Self-checking bench for kv_row_loader (M=4, N=44, 8-byte beats).
//            Expected row writes are queued as beats are sent and compared
//            against the write ports as strobes appear.
// Revision : 1.0 - initial release
// ============================================================================
module tb_kv_row_loader;

    localparam int M   = 4;
    localparam int N   = 44;
    localparam int BB  = 8;
    localparam int AW  = 2;
    localparam int BPR = 6;
    localparam int DW  = 8 * N;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          in_valid;
    logic [8*BB-1:0] in_data;
    logic          in_ready;
    logic          K_wr_en;
    logic [AW-1:0] K_wr_addr;
    logic [DW-1:0] K_wr_data;
    logic          V_wr_en;
    logic [AW-1:0] V_wr_addr;
    logic [DW-1:0] V_wr_data;
    logic          busy;
    logic          kv_loaded;

    kv_row_loader #(
        .M          (M),
        .N          (N),
        .BEAT_BYTES (BB),
        .AW         (AW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .K_wr_en   (K_wr_en),
        .K_wr_addr (K_wr_addr),
        .K_wr_data (K_wr_data),
        .V_wr_en   (V_wr_en),
        .V_wr_addr (V_wr_addr),
        .V_wr_data (V_wr_data),
        .busy      (busy),
        .kv_loaded (kv_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit            is_v;
        int            addr;
        logic [DW-1:0] data;
        bit            loaded;
    } wr_t;

    typedef struct {
        int gap_pct;
        bit garbage;
        int seed;
        int exp_strobes;
    } vec_t;

    wr_t q[$];
    int  n_checks  = 0;
    int  n_fail    = 0;
    int  n_strobes = 0;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Element k of global row g (K rows 0..M-1, V rows M..2M-1).
    function automatic logic [DW-1:0] row_val(input int g, input int seed);
        logic [DW-1:0] r;
        r = '0;
        for (int k = 0; k < N; k++) r[8*k +: 8] = 8'((g * N + k + seed) % 256);
        return r;
    endfunction

    function automatic logic [8*BB-1:0] beat_val(input int t, input int seed, input bit garbage);
        logic [8*BB-1:0] d;
        int g, b, idx;
        g = t / BPR;
        b = t % BPR;
        for (int i = 0; i < BB; i++) begin
            idx = b * BB + i;
            if (idx < N) d[8*i +: 8] = 8'((g * N + idx + seed) % 256);
            else         d[8*i +: 8] = garbage ? 8'hFF : 8'h00;
        end
        return d;
    endfunction

    // Scoreboard: every strobe must match the head of the expected queue.
    always @(negedge clk) begin
        if (K_wr_en || V_wr_en) begin
            wr_t e;
            n_strobes++;
            chk("exclusive_strobe", DW'(K_wr_en & V_wr_en), '0);
            chk("write_expected", DW'(q.size() != 0), DW'(1));
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("wr_matrix", DW'(V_wr_en), DW'(e.is_v));
                chk("wr_addr", DW'(e.is_v ? V_wr_addr : K_wr_addr), DW'(e.addr));
                chk("wr_data", e.is_v ? V_wr_data : K_wr_data, e.data);
                chk("kv_loaded_at_strobe", DW'(kv_loaded), DW'(e.loaded));
            end
        end
    end

    // All drive tasks start and end at 1 time unit after a rising edge.
    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_beats(input int nbeats, input int seed, input int gap_pct, input bit garbage);
        int g, w;
        for (int t = 0; t < nbeats; t++) begin
            g = t / BPR;
            while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_data  = beat_val(t, seed, garbage);
            w = 0;
            while (!in_ready && w < 100) begin
                @(posedge clk); #1;
                w++;
            end
            if (w >= 100) begin
                chk("ready_timeout", DW'(in_ready), DW'(1));
                in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
            if ((t % BPR) == BPR - 1)
                q.push_back('{is_v: (g >= M), addr: g % M, data: row_val(g, seed),
                              loaded: (g == 2 * M - 1)});
        end
        in_valid = 1'b0;
    endtask

    task automatic run_load(input vec_t v);
        n_strobes = 0;
        pulse_start();
        send_beats(2 * M * BPR, v.seed, v.gap_pct, v.garbage);
        idle(3);
        chk("strobe_count", DW'(n_strobes), DW'(v.exp_strobes));
        chk("loaded_after", DW'(kv_loaded), DW'(1));
        chk("busy_after", DW'(busy), '0);
        chk("ready_after", DW'(in_ready), '0);
        chk("queue_drained", DW'(q.size()), '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[4];
        vecs[0] = '{gap_pct: 0,  garbage: 1'b0, seed: 0,  exp_strobes: 8};
        vecs[1] = '{gap_pct: 0,  garbage: 1'b1, seed: 0,  exp_strobes: 8};
        vecs[2] = '{gap_pct: 50, garbage: 1'b0, seed: 0,  exp_strobes: 8};
        vecs[3] = '{gap_pct: 50, garbage: 1'b1, seed: 17, exp_strobes: 8};

        rst_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = '1;

        // Reset with the source presenting data
        idle(3);
        chk("rst_ctrl", DW'({in_ready, K_wr_en, K_wr_addr, V_wr_en, V_wr_addr, busy, kv_loaded}), '0);
        chk("rst_K_data", K_wr_data, '0);
        chk("rst_V_data", V_wr_data, '0);
        rst_n = 1'b1;
        idle(3);
        chk("idle_ready", DW'(in_ready), '0);
        chk("idle_busy", DW'(busy), '0);
        in_valid = 1'b0;

        // Full loads: plain, partial-beat garbage, random gaps
        for (int i = 0; i < 4; i++) run_load(vecs[i]);

        // Abort in K after 15 beats (row 2, beat 3); restart is a new load
        pulse_start();
        send_beats(15, 5, 0, 1'b0);
        idle(2);
        run_load('{gap_pct: 0, garbage: 1'b0, seed: 99, exp_strobes: 8});

        // start coincident with the final beat of K row 2: row is dropped
        pulse_start();
        send_beats(17, 6, 0, 1'b0);
        idle(2);
        in_valid = 1'b1;
        in_data  = beat_val(17, 6, 1'b0);
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("abort_no_write", DW'(K_wr_en), '0);
        @(posedge clk); #1;
        n_strobes = 0;
        send_beats(2 * M * BPR, 7, 0, 1'b0);
        idle(3);
        chk("post_abort_strobes", DW'(n_strobes), DW'(8));
        chk("post_abort_loaded", DW'(kv_loaded), DW'(1));

        // start in DONE clears kv_loaded on the next cycle
        pulse_start();
        chk("restart_loaded", DW'(kv_loaded), '0);
        chk("restart_busy", DW'(busy), DW'(1));

        // Reset in LOAD_V after V row 1 is written
        send_beats(4 * BPR + 2 * BPR, 8, 0, 1'b0);
        idle(2);
        chk("pre_rst_busy", DW'(busy), DW'(1));
        in_valid = 1'b1;
        in_data  = beat_val(36, 8, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_ctrl", DW'({in_ready, K_wr_en, K_wr_addr, V_wr_en, V_wr_addr, busy, kv_loaded}), '0);
        chk("midrst_K_data", K_wr_data, '0);
        chk("midrst_V_data", V_wr_data, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(4);
        chk("post_rst_ready", DW'(in_ready), '0);
        chk("post_rst_busy", DW'(busy), '0);
        chk("post_rst_loaded", DW'(kv_loaded), '0);
        in_valid = 1'b0;
        chk("final_queue", DW'(q.size()), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
